vec_mul_issuer: RTL

Producer side of the 4-lane product interface consumed by the pipelined 4-input adder tree.
- Accepts one pair of packed 8-bit operand vectors per handshake.
- Multiplies them element-wise and streams the products out four lanes per cycle with a valid strobe.
- Marks the first and last beat of each vector so a downstream accumulator can frame dot products.
- The interface has no backpressure. The block issues at full rate and supports back-to-back vectors with no bubble.

---
 rtl/vec_mul_issuer.sv | 114 +++++++++++
 1 files changed

// File: rtl/vec_mul_issuer.sv
// vec_mul_issuer: captures a pair of packed operand vectors and streams their
// element-wise unsigned products four lanes per beat, framed with first/last
// markers. Issues at full rate with no backpressure; a new vector can be
// captured on the final beat of the previous one so issue never bubbles.
//
// state | meaning
// IDLE  | no vector held; ready to capture
// ISSUE | emitting beats k = 0 .. BEATS-1 of the captured vector

module vec_mul_issuer #(
    parameter int VEC_LEN = 16,
    parameter int W_A     = 8,
    parameter int W_P     = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     vec_valid,
    output logic                     vec_ready,
    input  logic [VEC_LEN*W_A-1:0]   vec_a,
    input  logic [VEC_LEN*W_A-1:0]   vec_b,
    output logic                     out_valid,
    output logic [W_P-1:0]           p0,
    output logic [W_P-1:0]           p1,
    output logic [W_P-1:0]           p2,
    output logic [W_P-1:0]           p3,
    output logic                     out_first,
    output logic                     out_last,
    output logic                     busy
);

    localparam int BEATS  = VEC_LEN / 4;
    localparam int KW     = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int VW     = VEC_LEN * W_A;
    localparam int LANE_W = 4 * W_A;
    localparam logic [KW-1:0] K_LAST = KW'(BEATS - 1);

    typedef enum logic {
        IDLE,
        ISSUE
    } state_t;

    state_t          state;
    logic [KW-1:0]   k;
    logic [VW-1:0]   op_a;
    logic [VW-1:0]   op_b;
    logic            last_beat;
    logic [W_P-1:0]  prod [4];

    assign last_beat = (k == K_LAST);
    assign busy      = (state == ISSUE);
    assign vec_ready = rst_n && ((state == IDLE) || last_beat);

    // Lane products from the low four elements of the operand shift registers
    always_comb begin
        for (int j = 0; j < 4; j++) begin
            prod[j] = W_P'(op_a[j*W_A +: W_A]) * W_P'(op_b[j*W_A +: W_A]);
        end
    end

    // Issue state machine; operands shift down one beat per issued beat
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            k         <= '0;
            op_a      <= '0;
            op_b      <= '0;
            out_valid <= 1'b0;
            out_first <= 1'b0;
            out_last  <= 1'b0;
            p0        <= '0;
            p1        <= '0;
            p2        <= '0;
            p3        <= '0;
        end else begin
            out_valid <= 1'b0;
            out_first <= 1'b0;
            out_last  <= 1'b0;
            case (state)
                IDLE: begin
                    if (vec_valid) begin
                        op_a  <= vec_a;
                        op_b  <= vec_b;
                        k     <= '0;
                        state <= ISSUE;
                    end
                end
                ISSUE: begin
                    p0        <= prod[0];
                    p1        <= prod[1];
                    p2        <= prod[2];
                    p3        <= prod[3];
                    out_valid <= 1'b1;
                    out_first <= (k == '0);
                    out_last  <= last_beat;
                    if (last_beat) begin
                        k <= '0;
                        if (vec_valid) begin
                            op_a <= vec_a;
                            op_b <= vec_b;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        op_a <= op_a >> LANE_W;
                        op_b <= op_b >> LANE_W;
                        k    <= k + KW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
